// File: rtl/pixel_frame_streamer_if.sv
// pixel_frame_streamer_if
// Bundles the host-side write/control signals and the outgoing pixel stream
// of pixel_frame_streamer.
//   master : host/consumer side (drives writes, start, gap; observes stream)
//   slave  : the streamer itself
// Signals:
//   wr_en, wr_addr[13:0], wr_data[7:0] : frame memory write port
//   start, gap[3:0]                    : frame request and inter-pixel gap
//   pattern_mode                       : only with STREAMER_TEST_PATTERN_EN
//   busy, pixel_out_valid, pixel_out[7:0], line_end, frame_done : status/stream
interface pixel_frame_streamer_if;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic [3:0]  gap;
`ifdef STREAMER_TEST_PATTERN_EN
  logic        pattern_mode;
`endif
  logic        busy;
  logic        pixel_out_valid;
  logic [7:0]  pixel_out;
  logic        line_end;
  logic        frame_done;

  modport master (
`ifdef STREAMER_TEST_PATTERN_EN
    output pattern_mode,
`endif
    output wr_en, wr_addr, wr_data, start, gap,
    input  busy, pixel_out_valid, pixel_out, line_end, frame_done
  );

  modport slave (
`ifdef STREAMER_TEST_PATTERN_EN
    input  pattern_mode,
`endif
    input  wr_en, wr_addr, wr_data, start, gap,
    output busy, pixel_out_valid, pixel_out, line_end, frame_done
  );
endinterface

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer
// Holds one IMAGE_WIDTH x IMAGE_HEIGHT 8-bit frame written by a host and, on
// start, streams it in raster order with a programmable idle gap between
// pixels (e.g. into a Sobel accelerator's pixel_in/pixel_in_valid).
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : pixel_frame_streamer_if.slave (write port, start/gap, stream out)
// Optional feature: define STREAMER_TEST_PATTERN_EN to add bus.pattern_mode;
// when latched high the frame streams (row+col)[7:0] instead of memory data.
module pixel_frame_streamer #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_frame_streamer_if.slave bus
);

  localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, GAP, DONE} state_t;

  state_t          state_r;
  logic [6:0]      col_r;
  logic [6:0]      row_r;
  logic [AW-1:0]   rd_addr_r;
  logic [3:0]      gap_r;
  logic [3:0]      gap_cnt_r;
  logic            busy_r;
  logic            valid_r;
  logic [7:0]      pixel_r;
  logic            line_end_r;
  logic            frame_done_r;
`ifdef STREAMER_TEST_PATTERN_EN
  logic            pattern_r;
`endif

  // Power-of-two sized so the read address indexes it without width games;
  // writes beyond DEPTH are rejected before reaching it.
  logic [7:0]      mem [2**AW];

  logic            last_col_s;
  logic            last_pix_s;
  logic            wr_ok_s;
  logic [7:0]      pixel_src_s;

  assign last_col_s = (col_r == 7'(IMAGE_WIDTH - 1));
  assign last_pix_s = last_col_s && (row_r == 7'(IMAGE_HEIGHT - 1));
  assign wr_ok_s    = bus.wr_en && !busy_r && ({1'b0, bus.wr_addr} < 15'(DEPTH));

  assign bus.busy            = busy_r;
  assign bus.pixel_out_valid = valid_r;
  assign bus.pixel_out       = pixel_r;
  assign bus.line_end        = line_end_r;
  assign bus.frame_done      = frame_done_r;

  // Pixel source: memory word at the read address, or the test pattern.
  always_comb begin
    pixel_src_s = mem[rd_addr_r];
`ifdef STREAMER_TEST_PATTERN_EN
    if (pattern_r) begin
      pixel_src_s = {1'b0, row_r} + {1'b0, col_r};
    end else begin
      pixel_src_s = mem[rd_addr_r];
    end
`endif
  end

  // Host write port into the frame memory; blocked while streaming.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end

  // Streaming FSM; the memory read in READ is registered straight into
  // pixel_r so data and valid appear together one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      col_r        <= 7'd0;
      row_r        <= 7'd0;
      rd_addr_r    <= '0;
      gap_r        <= 4'd0;
      gap_cnt_r    <= 4'd0;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      pixel_r      <= 8'd0;
      line_end_r   <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef STREAMER_TEST_PATTERN_EN
      pattern_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          valid_r      <= 1'b0;
          line_end_r   <= 1'b0;
          frame_done_r <= 1'b0;
          if (bus.start) begin
            gap_r     <= bus.gap;
            col_r     <= 7'd0;
            row_r     <= 7'd0;
            rd_addr_r <= '0;
            busy_r    <= 1'b1;
`ifdef STREAMER_TEST_PATTERN_EN
            pattern_r <= bus.pattern_mode;
`endif
            state_r   <= READ;
          end
        end
        READ: begin
          valid_r    <= 1'b1;
          pixel_r    <= pixel_src_s;
          line_end_r <= last_col_s;
          rd_addr_r  <= rd_addr_r + 1'b1;
          if (last_col_s) begin
            col_r <= 7'd0;
            row_r <= row_r + 7'd1;
          end else begin
            col_r <= col_r + 7'd1;
          end
          // The final pixel never takes a gap: frame_done follows it directly.
          if (last_pix_s) begin
            state_r <= DONE;
          end else if (gap_r != 4'd0) begin
            gap_cnt_r <= gap_r - 4'd1;
            state_r   <= GAP;
          end else begin
            state_r <= READ;
          end
        end
        GAP: begin
          valid_r    <= 1'b0;
          line_end_r <= 1'b0;
          if (gap_cnt_r == 4'd0) begin
            state_r <= READ;
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
          end
        end
        DONE: begin
          // Two cycles here: first raises frame_done (busy still high),
          // second drops both and returns to IDLE.
          valid_r    <= 1'b0;
          line_end_r <= 1'b0;
          if (!frame_done_r) begin
            frame_done_r <= 1'b1;
          end else begin
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          valid_r      <= 1'b0;
          line_end_r   <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
